conv_pe_ctrl: RTL and testbench

Sequencer for the 3x3 convolution PE array. It walks one frame per (output-tile, input-tile) pass. It issues IFM-buffer and filter-buffer read requests and drives the PE strobes (`t_data_run`, `t_cal_start`, border flags, `load_filter`/`load_idx`/`change_filter`). It also tags each PE result with its row, column and pass position for the downstream psum accumulator. It sits between the layer controller (start/cfg/done) and `conv_pe` plus its buffer manager.

---
 rtl/conv_pe_ctrl_pkg.sv | 38 +++
 rtl/conv_pe_ctrl_if.sv | 57 +++++
 rtl/conv_pe_ctrl_tag_delay_line.sv | 41 ++++
 rtl/conv_pe_ctrl.sv | 227 ++++++++++++++++++++++
 tb/tb_conv_pe_ctrl.sv | 292 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/conv_pe_ctrl_pkg.sv
// Shared constants, FSM encoding and pipeline payload types for the 3x3 PE sequencer.
package conv_pe_ctrl_pkg;

    localparam int K         = 3;
    localparam int Tin       = 4;
    localparam int W_Tin     = 2;
    localparam int W_SIZE    = 10;
    localparam int W_CHANNEL = 6;
    localparam int PE_DELAY  = 4;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_FLOAD = 3'd1;
    localparam logic [2:0] ST_FWAIT = 3'd2;
    localparam logic [2:0] ST_SWAP  = 3'd3;
    localparam logic [2:0] ST_PRIME = 3'd4;
    localparam logic [2:0] ST_CALC  = 3'd5;
    localparam logic [2:0] ST_DRAIN = 3'd6;
    localparam logic [2:0] ST_DONE  = 3'd7;

    typedef struct packed {
        logic [W_SIZE-1:0] row;
        logic [W_SIZE-1:0] col;
        logic              first_itile;
        logic              last_itile;
    } tag_t;

    typedef struct packed {
        logic             run;
        logic             cal;
        logic             first_row;
        logic             last_row;
        logic             first_col;
        logic             last_col;
        logic             load;
        logic [W_Tin-1:0] load_idx;
    } pe_strobe_t;

endpackage

// File: rtl/conv_pe_ctrl_if.sv
// Control, buffer-request, PE-strobe and result-tag bundle around the sequencer.
interface conv_pe_ctrl_if;
    import conv_pe_ctrl_pkg::*;

    logic                 start;
    logic [W_SIZE-1:0]    cfg_width;
    logic [W_SIZE-1:0]    cfg_height;
    logic [W_CHANNEL-1:0] cfg_n_itile;
    logic [W_CHANNEL-1:0] cfg_n_otile;
    logic                 busy;
    logic                 done;
    logic                 ifm_rd_en;
    logic [W_SIZE-1:0]    ifm_rd_row;
    logic [W_SIZE-1:0]    ifm_rd_col;
    logic [W_CHANNEL-1:0] ifm_rd_itile;
    logic                 flt_rd_en;
    logic [W_Tin-1:0]     flt_rd_idx;
    logic [W_CHANNEL-1:0] flt_rd_itile;
    logic [W_CHANNEL-1:0] flt_rd_otile;
    logic                 t_data_run;
    logic                 t_cal_start;
    logic                 c_is_first_row;
    logic                 c_is_last_row;
    logic                 c_is_first_col;
    logic                 c_is_last_col;
    logic                 load_filter;
    logic [W_Tin-1:0]     load_idx;
    logic                 change_filter;
    logic                 o_tag_vld;
    logic [W_SIZE-1:0]    o_row;
    logic [W_SIZE-1:0]    o_col;
    logic                 o_first_itile;
    logic                 o_last_itile;

    modport master (
        input  start, cfg_width, cfg_height, cfg_n_itile, cfg_n_otile,
        output busy, done,
        output ifm_rd_en, ifm_rd_row, ifm_rd_col, ifm_rd_itile,
        output flt_rd_en, flt_rd_idx, flt_rd_itile, flt_rd_otile,
        output t_data_run, t_cal_start,
        output c_is_first_row, c_is_last_row, c_is_first_col, c_is_last_col,
        output load_filter, load_idx, change_filter,
        output o_tag_vld, o_row, o_col, o_first_itile, o_last_itile
    );

    modport slave (
        output start, cfg_width, cfg_height, cfg_n_itile, cfg_n_otile,
        input  busy, done,
        input  ifm_rd_en, ifm_rd_row, ifm_rd_col, ifm_rd_itile,
        input  flt_rd_en, flt_rd_idx, flt_rd_itile, flt_rd_otile,
        input  t_data_run, t_cal_start,
        input  c_is_first_row, c_is_last_row, c_is_first_col, c_is_last_col,
        input  load_filter, load_idx, change_filter,
        input  o_tag_vld, o_row, o_col, o_first_itile, o_last_itile
    );

endinterface

// File: rtl/conv_pe_ctrl_tag_delay_line.sv
// Fixed-depth valid+payload shift register; matches result tags to the PE pipeline latency.
module tag_delay_line #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             in_vld,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_vld,
    output logic [WIDTH-1:0] out_data
);

    logic [DEPTH-1:0] vld_q, vld_d;
    logic [WIDTH-1:0] data_q [DEPTH];
    logic [WIDTH-1:0] data_d [DEPTH];

    always_comb begin
        vld_d[0]  = in_vld;
        data_d[0] = in_data;
        for (int i = 1; i < DEPTH; i++) begin
            vld_d[i]  = vld_q[i-1];
            data_d[i] = data_q[i-1];
        end
    end

    // NOTE: payload stages are reset too, so a reset mid-frame leaves no stale tag on o_row/o_col.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            vld_q <= '0;
            for (int i = 0; i < DEPTH; i++) data_q[i] <= '0;
        end else begin
            vld_q  <= vld_d;
            data_q <= data_d;
        end
    end

    assign out_vld  = vld_q[DEPTH-1];
    assign out_data = data_q[DEPTH-1];

endmodule

// File: rtl/conv_pe_ctrl.sv
// Frame sequencer for the 3x3 conv PE array: filter load/prefetch, column reads, PE strobes, result tags.
module conv_pe_ctrl
    import conv_pe_ctrl_pkg::*;
(
    input  logic           clk,
    input  logic           rstn,
    conv_pe_ctrl_if.master bus
);

    logic [2:0]           state_q, state_d;
    logic [W_SIZE-1:0]    step_q, step_d;
    logic [W_SIZE-1:0]    row_q, row_d;
    logic [W_CHANNEL-1:0] it_q, it_d, ot_q, ot_d;
    logic [W_Tin:0]       pf_cnt_q, pf_cnt_d;
    logic [W_SIZE-1:0]    width_q, width_d, height_q, height_d;
    logic [W_CHANNEL-1:0] n_it_q, n_it_d, n_ot_q, n_ot_d;
    pe_strobe_t           s1_q, s1_d;
    tag_t                 s1_tag_q, s1_tag_d;
    tag_t                 tag_out;
    logic                 tag_vld;

    logic                 last_it, last_pass, calc;
    logic [W_CHANNEL-1:0] next_it, next_ot;
    logic                 ifm_rd_en, flt_rd_en;
    logic [W_SIZE-1:0]    ifm_rd_col;
    logic [W_Tin-1:0]     flt_rd_idx;
    logic [W_CHANNEL-1:0] flt_rd_itile, flt_rd_otile;

    always_comb begin
        last_it   = (it_q == n_it_q - W_CHANNEL'(1));
        last_pass = last_it && (ot_q == n_ot_q - W_CHANNEL'(1));
        next_it   = last_it ? '0 : it_q + W_CHANNEL'(1);
        next_ot   = !last_it ? ot_q : (ot_q == n_ot_q - W_CHANNEL'(1)) ? '0 : ot_q + W_CHANNEL'(1);
    end

    // NOTE: every output of this block gets a default first so no path can infer a latch.
    always_comb begin
        state_d      = state_q;
        step_d       = step_q;
        row_d        = row_q;
        it_d         = it_q;
        ot_d         = ot_q;
        pf_cnt_d     = pf_cnt_q;
        width_d      = width_q;
        height_d     = height_q;
        n_it_d       = n_it_q;
        n_ot_d       = n_ot_q;
        ifm_rd_en    = 1'b0;
        ifm_rd_col   = '0;
        flt_rd_en    = 1'b0;
        flt_rd_idx   = '0;
        flt_rd_itile = '0;
        flt_rd_otile = '0;
        calc         = 1'b0;

        // Shadow-bank prefetch of the next pass's filters while the current pass computes.
        if ((state_q == ST_PRIME || state_q == ST_CALC) && !last_pass && pf_cnt_q < (W_Tin+1)'(Tin)) begin
            flt_rd_en    = 1'b1;
            flt_rd_idx   = pf_cnt_q[W_Tin-1:0];
            flt_rd_itile = next_it;
            flt_rd_otile = next_ot;
            pf_cnt_d     = pf_cnt_q + (W_Tin+1)'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    width_d  = bus.cfg_width;
                    height_d = bus.cfg_height;
                    n_it_d   = bus.cfg_n_itile;
                    n_ot_d   = bus.cfg_n_otile;
                    step_d   = '0;
                    row_d    = '0;
                    it_d     = '0;
                    ot_d     = '0;
                    pf_cnt_d = '0;
                    state_d  = ST_FLOAD;
                end
            end
            ST_FLOAD: begin
                flt_rd_en    = 1'b1;
                flt_rd_idx   = step_q[W_Tin-1:0];
                flt_rd_itile = it_q;
                flt_rd_otile = ot_q;
                if (step_q == W_SIZE'(Tin - 1)) begin
                    step_d  = '0;
                    state_d = ST_FWAIT;
                end else begin
                    step_d = step_q + W_SIZE'(1);
                end
            end
            ST_FWAIT: state_d = ST_SWAP;
            ST_SWAP: begin
                step_d  = '0;
                state_d = ST_PRIME;
            end
            ST_PRIME: begin
                ifm_rd_en  = 1'b1;
                ifm_rd_col = step_q;
                if (step_q == W_SIZE'(K - 2)) begin
                    step_d  = '0;
                    state_d = ST_CALC;
                end else begin
                    step_d = step_q + W_SIZE'(1);
                end
            end
            ST_CALC: begin
                calc = 1'b1;
                if ({1'b0, step_q} + (W_SIZE+1)'(2) < {1'b0, width_q}) begin
                    ifm_rd_en  = 1'b1;
                    ifm_rd_col = step_q + W_SIZE'(2);
                end
                if (step_q == width_q - W_SIZE'(1)) begin
                    step_d = '0;
                    if (row_q != height_q - W_SIZE'(1)) begin
                        row_d   = row_q + W_SIZE'(1);
                        state_d = ST_PRIME;
                    end else if (!last_pass) begin
                        row_d    = '0;
                        it_d     = next_it;
                        ot_d     = next_ot;
                        pf_cnt_d = '0;
                        state_d  = ST_SWAP;
                    end else begin
                        state_d = ST_DRAIN;
                    end
                end else begin
                    step_d = step_q + W_SIZE'(1);
                end
            end
            ST_DRAIN: begin
                if (step_q == W_SIZE'(PE_DELAY)) state_d = ST_DONE;
                else                             step_d  = step_q + W_SIZE'(1);
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Stage 1: the calculate and its border flags share the register that delays the column push.
    always_comb begin
        s1_d          = '0;
        s1_d.run      = ifm_rd_en;
        s1_d.load     = flt_rd_en;
        s1_d.load_idx = flt_rd_idx;
        s1_tag_d      = '0;
        if (calc) begin
            s1_d.cal             = 1'b1;
            s1_d.first_row       = (row_q == '0);
            s1_d.last_row        = (row_q == height_q - W_SIZE'(1));
            s1_d.first_col       = (step_q == '0);
            s1_d.last_col        = (step_q == width_q - W_SIZE'(1));
            s1_tag_d.row         = row_q;
            s1_tag_d.col         = step_q;
            s1_tag_d.first_itile = (it_q == '0);
            s1_tag_d.last_itile  = last_it;
        end
    end

    // NOTE: state flops use non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= ST_IDLE;
            step_q   <= '0;
            row_q    <= '0;
            it_q     <= '0;
            ot_q     <= '0;
            pf_cnt_q <= '0;
            width_q  <= '0;
            height_q <= '0;
            n_it_q   <= '0;
            n_ot_q   <= '0;
            s1_q     <= '0;
            s1_tag_q <= '0;
        end else begin
            state_q  <= state_d;
            step_q   <= step_d;
            row_q    <= row_d;
            it_q     <= it_d;
            ot_q     <= ot_d;
            pf_cnt_q <= pf_cnt_d;
            width_q  <= width_d;
            height_q <= height_d;
            n_it_q   <= n_it_d;
            n_ot_q   <= n_ot_d;
            s1_q     <= s1_d;
            s1_tag_q <= s1_tag_d;
        end
    end

    tag_delay_line #(
        .DEPTH (PE_DELAY),
        .WIDTH ($bits(tag_t))
    ) u_tag_delay (
        .clk      (clk),
        .rstn     (rstn),
        .in_vld   (s1_q.cal),
        .in_data  (s1_tag_q),
        .out_vld  (tag_vld),
        .out_data (tag_out)
    );

    assign bus.busy           = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign bus.done           = (state_q == ST_DONE);
    assign bus.ifm_rd_en      = ifm_rd_en;
    assign bus.ifm_rd_row     = ifm_rd_en ? row_q : '0;
    assign bus.ifm_rd_col     = ifm_rd_col;
    assign bus.ifm_rd_itile   = ifm_rd_en ? it_q : '0;
    assign bus.flt_rd_en      = flt_rd_en;
    assign bus.flt_rd_idx     = flt_rd_idx;
    assign bus.flt_rd_itile   = flt_rd_itile;
    assign bus.flt_rd_otile   = flt_rd_otile;
    assign bus.t_data_run     = s1_q.run;
    assign bus.t_cal_start    = s1_q.cal;
    assign bus.c_is_first_row = s1_q.first_row;
    assign bus.c_is_last_row  = s1_q.last_row;
    assign bus.c_is_first_col = s1_q.first_col;
    assign bus.c_is_last_col  = s1_q.last_col;
    assign bus.load_filter    = s1_q.load;
    assign bus.load_idx       = s1_q.load_idx;
    assign bus.change_filter  = (state_q == ST_SWAP);
    assign bus.o_tag_vld      = tag_vld;
    assign bus.o_row          = tag_out.row;
    assign bus.o_col          = tag_out.col;
    assign bus.o_first_itile  = tag_out.first_itile;
    assign bus.o_last_itile   = tag_out.last_itile;

endmodule

// File: tb/tb_conv_pe_ctrl.sv
// Bench for conv_pe_ctrl: a per-cycle schedule model built from pass/row arithmetic plus literal pins.
module tb_conv_pe_ctrl;
    import conv_pe_ctrl_pkg::*;

    localparam int MAXT = 4096;

    typedef struct packed {
        logic                 busy, done;
        logic                 ifm_en;
        logic [W_SIZE-1:0]    ifm_row, ifm_col;
        logic [W_CHANNEL-1:0] ifm_it;
        logic                 flt_en;
        logic [W_Tin-1:0]     flt_idx;
        logic [W_CHANNEL-1:0] flt_it, flt_ot;
        logic                 run, cal, frow, lrow, fcol, lcol;
        logic                 ld;
        logic [W_Tin-1:0]     ld_idx;
        logic                 chg;
        logic                 tv;
        logic [W_SIZE-1:0]    trow, tcol;
        logic                 tfirst, tlast;
    } obs_t;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    int   cyc  = 0;
    int   base = 0;
    bit   model_on = 1'b0;
    bit   mon_on   = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;
    obs_t exp_tab [MAXT];
    int   exp_len = 0;
    int   n_tag, n_done, n_chg, n_overlap, n_fcol, n_lcol, n_first_it, n_last_it, n_flt11;
    int   first_chg, first_tag, done_off;

    conv_pe_ctrl_if bus ();

    conv_pe_ctrl dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    function automatic obs_t sample();
        obs_t o;
        o.busy = bus.busy;           o.done = bus.done;
        o.ifm_en = bus.ifm_rd_en;    o.ifm_row = bus.ifm_rd_row;
        o.ifm_col = bus.ifm_rd_col;  o.ifm_it = bus.ifm_rd_itile;
        o.flt_en = bus.flt_rd_en;    o.flt_idx = bus.flt_rd_idx;
        o.flt_it = bus.flt_rd_itile; o.flt_ot = bus.flt_rd_otile;
        o.run = bus.t_data_run;      o.cal = bus.t_cal_start;
        o.frow = bus.c_is_first_row; o.lrow = bus.c_is_last_row;
        o.fcol = bus.c_is_first_col; o.lcol = bus.c_is_last_col;
        o.ld = bus.load_filter;      o.ld_idx = bus.load_idx;
        o.chg = bus.change_filter;   o.tv = bus.o_tag_vld;
        o.trow = bus.o_row;          o.tcol = bus.o_col;
        o.tfirst = bus.o_first_itile; o.tlast = bus.o_last_itile;
        return o;
    endfunction

    // Payloads are only meaningful while their strobe is high.
    function automatic obs_t mask(input obs_t o);
        obs_t m;
        m = o;
        if (!m.ifm_en) begin m.ifm_row = '0; m.ifm_col = '0; m.ifm_it = '0; end
        if (!m.flt_en) begin m.flt_idx = '0; m.flt_it = '0; m.flt_ot = '0; end
        if (!m.ld) m.ld_idx = '0;
        if (!m.tv) begin m.trow = '0; m.tcol = '0; m.tfirst = 1'b0; m.tlast = 1'b0; end
        return m;
    endfunction

    // Expected trace indexed by cycles since the start edge, from the pass/row/column schedule.
    task automatic build_model(input int w, input int h, input int nit, input int nott);
        int np, b, s, t, cc, pit;
        for (int i = 0; i < MAXT; i++) exp_tab[i] = '0;
        np = nit * nott;
        for (int k = 0; k < Tin; k++) begin
            exp_tab[1+k].flt_en  = 1'b1;
            exp_tab[1+k].flt_idx = W_Tin'(k);
        end
        exp_tab[Tin+2].chg = 1'b1;
        b = Tin + 3;
        for (int p = 0; p < np; p++) begin
            pit = p % nit;
            if (p > 0) exp_tab[b-1].chg = 1'b1;
            if (p < np - 1) begin
                for (int k = 0; k < Tin; k++) begin
                    exp_tab[b+k].flt_en  = 1'b1;
                    exp_tab[b+k].flt_idx = W_Tin'(k);
                    exp_tab[b+k].flt_it  = W_CHANNEL'((p + 1) % nit);
                    exp_tab[b+k].flt_ot  = W_CHANNEL'((p + 1) / nit);
                end
            end
            for (int r = 0; r < h; r++) begin
                s = b + r * (w + 2);
                for (int c = 0; c < w; c++) begin
                    t = s + c;
                    exp_tab[t].ifm_en  = 1'b1;
                    exp_tab[t].ifm_row = W_SIZE'(r);
                    exp_tab[t].ifm_col = W_SIZE'(c);
                    exp_tab[t].ifm_it  = W_CHANNEL'(pit);
                    exp_tab[t+1].run   = 1'b1;
                    cc = s + 2 + c + 1;
                    exp_tab[cc].cal  = 1'b1;
                    exp_tab[cc].frow = (r == 0);
                    exp_tab[cc].lrow = (r == h - 1);
                    exp_tab[cc].fcol = (c == 0);
                    exp_tab[cc].lcol = (c == w - 1);
                    t = cc + PE_DELAY;
                    exp_tab[t].tv     = 1'b1;
                    exp_tab[t].trow   = W_SIZE'(r);
                    exp_tab[t].tcol   = W_SIZE'(c);
                    exp_tab[t].tfirst = (pit == 0);
                    exp_tab[t].tlast  = (pit == nit - 1);
                end
            end
            b = b + h * (w + 2) + 1;
        end
        for (int i = 1; i < b + PE_DELAY; i++) exp_tab[i].busy = 1'b1;
        exp_tab[b+PE_DELAY].done = 1'b1;
        exp_len = b + PE_DELAY + 1;
        for (int i = 1; i < exp_len; i++) begin
            if (exp_tab[i-1].flt_en) begin
                exp_tab[i].ld     = 1'b1;
                exp_tab[i].ld_idx = exp_tab[i-1].flt_idx;
            end
        end
    endtask

    always @(negedge clk) begin
        if (model_on) begin
            int   off;
            obs_t e;
            off = cyc - base;
            e = (off >= 0 && off < exp_len) ? exp_tab[off] : '0;
            check($sformatf("cycle+%0d", off), mask(sample()), e);
        end
    end

    always @(negedge clk) begin
        if (mon_on) begin
            if (bus.o_tag_vld) begin
                n_tag++;
                if (first_tag < 0) first_tag = cyc - base;
                if (bus.o_first_itile) n_first_it++;
                if (bus.o_last_itile) n_last_it++;
            end
            if (bus.done) begin n_done++; done_off = cyc - base; end
            if (bus.change_filter) begin
                n_chg++;
                if (first_chg < 0) first_chg = cyc - base;
            end
            if (bus.t_data_run && bus.t_cal_start) n_overlap++;
            if (bus.c_is_first_col) n_fcol++;
            if (bus.c_is_last_col) n_lcol++;
            if (bus.flt_rd_en && bus.flt_rd_itile == 1 && bus.flt_rd_otile == 1) n_flt11++;
        end
    end

    task automatic clear_mon();
        n_tag = 0; n_done = 0; n_chg = 0; n_overlap = 0; n_fcol = 0; n_lcol = 0;
        n_first_it = 0; n_last_it = 0; n_flt11 = 0;
        first_chg = -1; first_tag = -1; done_off = -1;
    endtask

    task automatic launch(input int w, input int h, input int nit, input int nott);
        @(negedge clk);
        bus.cfg_width   = W_SIZE'(w);
        bus.cfg_height  = W_SIZE'(h);
        bus.cfg_n_itile = W_CHANNEL'(nit);
        bus.cfg_n_otile = W_CHANNEL'(nott);
        bus.start       = 1'b1;
        base            = cyc;
        model_on        = 1'b1;
        mon_on          = 1'b1;
    endtask

    // busy_off: offset at which a stray start with a different config is pulsed (-1: none).
    task automatic run_frame(input int w, input int h, input int nit, input int nott,
                             input int busy_off, input bit start_at_done);
        int off;
        build_model(w, h, nit, nott);
        clear_mon();
        launch(w, h, nit, nott);
        off = 0;
        while (off < exp_len + 3) begin
            @(negedge clk);
            off = cyc - base;
            bus.start = (off == busy_off) || (start_at_done && off == exp_len - 1);
            if (off == busy_off) begin
                bus.cfg_width   = W_SIZE'(w + 5);
                bus.cfg_height  = W_SIZE'(h + 3);
                bus.cfg_n_itile = W_CHANNEL'(2);
            end
        end
        bus.start = 1'b0;
        model_on  = 1'b0;
        mon_on    = 1'b0;
    endtask

    initial begin
        int w, h, nit, nott;
        bus.start       = 1'b0;
        bus.cfg_width   = '0;
        bus.cfg_height  = '0;
        bus.cfg_n_itile = '0;
        bus.cfg_n_otile = '0;
        repeat (2) @(negedge clk);
        check("reset_outputs", sample(), '0);
        rstn = 1'b1;

        run_frame(4, 3, 1, 1, -1, 1'b0);
        check("A_first_change", first_chg, 6);
        check("A_change_count", n_chg, 1);
        check("A_first_tag", first_tag, 14);
        check("A_tag_count", n_tag, 12);
        check("A_done_offset", done_off, 30);
        check("A_done_count", n_done, 1);
        check("A_run_cal_overlap", n_overlap, 6);

        run_frame(4, 3, 1, 1, 12, 1'b1);
        check("A2_tag_count", n_tag, 12);
        check("A2_done_count", n_done, 1);
        check("A2_done_offset", done_off, 30);

        run_frame(2, 2, 1, 1, -1, 1'b0);
        check("B_run_cal_overlap", n_overlap, 0);
        check("B_first_col", n_fcol, 2);
        check("B_last_col", n_lcol, 2);
        check("B_tag_count", n_tag, 4);

        run_frame(3, 2, 2, 2, -1, 1'b0);
        check("C_change_count", n_chg, 4);
        check("C_tag_count", n_tag, 24);
        check("C_first_itile", n_first_it, 12);
        check("C_last_itile", n_last_it, 12);
        check("C_prefetch_11", n_flt11, Tin);
        check("C_done_offset", done_off, 55);

        // Abort in the middle of row 1 CALC of an 8-wide frame.
        build_model(8, 4, 1, 1);
        clear_mon();
        launch(8, 4, 1, 1);
        while (cyc - base < 20) begin
            @(negedge clk);
            bus.start = 1'b0;
        end
        model_on = 1'b0;
        mon_on   = 1'b0;
        rstn     = 1'b0;
        #1;
        check("abort_async", sample(), '0);
        @(negedge clk);
        check("abort_next_edge", sample(), '0);
        rstn = 1'b1;
        clear_mon();
        mon_on = 1'b1;
        repeat (40) @(negedge clk);
        mon_on = 1'b0;
        check("abort_no_done", n_done, 0);
        check("abort_no_tag", n_tag, 0);

        run_frame(5, 3, 1, 2, -1, 1'b0);
        check("D_tag_count", n_tag, 30);

        for (int i = 0; i < 4; i++) begin
            w    = $urandom_range(2, 16);
            h    = $urandom_range(2, 16);
            nit  = $urandom_range(1, 2);
            nott = $urandom_range(1, 2);
            run_frame(w, h, nit, nott, -1, 1'b0);
            check($sformatf("R%0d_tag_count", i), n_tag, w * h * nit * nott);
            check($sformatf("R%0d_done_count", i), n_done, 1);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
